// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and index helpers for the RAMp2 port arbiter.
// Default sizes match the RAMp2 instance this arbiter normally fronts.
package ram_port_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_K     = 3;
  localparam int DEF_N     = 4;
  localparam int DEF_LG    = 2;

  // Wraps an index that is known to lie in [0, 2n) back into [0, n).
  function automatic int idx_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotating first-one finder: returns the first set mask bit at or after
// start, searching start, start+1, ... modulo n.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int n  = DEF_N,
  parameter int lg = DEF_LG
) (
  input  logic [n-1:0]  mask,
  input  logic [lg-1:0] start,
  output logic          found,
  output logic [lg-1:0] idx
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    found = 1'b0;
    idx   = '0;
    j     = 0;
    // Scan farthest offset first so the nearest hit overwrites it.
    for (int o = n - 1; o >= 0; o--) begin
      j = idx_wrap(int'(start) + o, n);
      if (mask[j]) begin
        found = 1'b1;
        idx   = lg'(j);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAMp2 (port 1 read/write, port 2 read-only)
// among n requesters; up to two grants per cycle, read data registered.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int k     = DEF_K,
  parameter int n     = DEF_N,
  parameter int lg    = DEF_LG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [n-1:0]       req,
  input  logic [n-1:0]       we,
  input  logic [n*k-1:0]     addr,
  input  logic [n*width-1:0] wdata,
  output logic [n-1:0]       gnt,
  output logic [n-1:0]       rvalid,
  output logic [n*width-1:0] rdata,
  output logic               ram_load,
  output logic [width-1:0]   ram_in,
  output logic [k-1:0]       ram_address1,
  output logic [k-1:0]       ram_address2,
  input  logic [width-1:0]   ram_out1,
  input  logic [width-1:0]   ram_out2
);

  logic [lg-1:0]      ptr_q, ptr_d;
  logic [n-1:0]       rvalid_q, rvalid_d;
  logic [n*width-1:0] rdata_q, rdata_d;

  logic               w1_found, w2_found;
  logic [lg-1:0]      w1_idx, w2_idx, w2_start;
  logic [n-1:0]       w2_mask;
  logic               p1_write;

  rr_pick #(.n(n), .lg(lg)) u_pick_w1 (
    .mask  (req),
    .start (ptr_q),
    .found (w1_found),
    .idx   (w1_idx)
  );

  // Port 2 may only take reads that come after w1 and before wrapping back
  // to ptr, so it never steals a client that port 1 would reach first.
  always_comb begin
    int off_w1;
    int off_j;
    w2_mask  = '0;
    off_j    = 0;
    off_w1   = idx_wrap(int'(w1_idx) + n - int'(ptr_q), n);
    w2_start = lg'(idx_wrap(int'(w1_idx) + 1, n));
    for (int j = 0; j < n; j++) begin
      off_j      = idx_wrap(j + n - int'(ptr_q), n);
      w2_mask[j] = w1_found & req[j] & ~we[j] & (off_j > off_w1);
    end
  end

  rr_pick #(.n(n), .lg(lg)) u_pick_w2 (
    .mask  (w2_mask),
    .start (w2_start),
    .found (w2_found),
    .idx   (w2_idx)
  );

  always_comb begin
    gnt = '0;
    if (w1_found) gnt[w1_idx] = 1'b1;
    if (w2_found) gnt[w2_idx] = 1'b1;
  end

  // Reset gates the write strobe combinationally so an in-flight write
  // cannot land while reset is asserted.
  assign p1_write = w1_found & we[w1_idx] & ~reset;

  always_comb begin
    ram_load     = p1_write;
    ram_in       = p1_write ? wdata[int'(w1_idx)*width +: width] : '0;
    ram_address1 = w1_found ? addr[int'(w1_idx)*k +: k] : '0;
    ram_address2 = w2_found ? addr[int'(w2_idx)*k +: k] : '0;
  end

  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (w1_found && !we[w1_idx]) begin
      rdata_d[int'(w1_idx)*width +: width] = ram_out1;
      rvalid_d[w1_idx]                     = 1'b1;
    end
    if (w2_found) begin
      rdata_d[int'(w2_idx)*width +: width] = ram_out2;
      rvalid_d[w2_idx]                     = 1'b1;
    end
    if (w2_found)      ptr_d = lg'(idx_wrap(int'(w2_idx) + 1, n));
    else if (w1_found) ptr_d = lg'(idx_wrap(int'(w1_idx) + 1, n));
  end

  // NOTE: rdata is an ordinary register bank, not a RAM, and must read as
  // zero after reset, so it is cleared along with the other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: table-driven vectors with a read
// scoreboard, plus hand sequences for fairness and mid-transfer reset.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req, we;
  logic [11:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt, rvalid;
  logic [63:0] rdata;
  logic        ram_load;
  logic [15:0] ram_in, ram_out1, ram_out2;
  logic [2:0]  ram_address1, ram_address2;

  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.width(16), .k(3), .n(4), .lg(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .ram_load     (ram_load),
    .ram_in       (ram_in),
    .ram_address1 (ram_address1),
    .ram_address2 (ram_address2),
    .ram_out1     (ram_out1),
    .ram_out2     (ram_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAMp2 model: combinational reads, write on rising edge, plus a backdoor
  // port used only to preload contents while the arbiter is held in reset.
  logic [15:0] mem [8];
  logic        bd_we;
  logic [2:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (ram_load)   mem[ram_address1] <= ram_in;
    else if (bd_we) mem[bd_addr]      <= bd_data;
  end
  assign ram_out1 = mem[ram_address1];
  assign ram_out2 = mem[ram_address2];

  typedef struct packed {
    logic [1:0]  client;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [3:0]  gnt;
    logic        load;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [15:0] din;
    logic [63:0] rd;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] r, input logic [3:0] w,
                       input logic [11:0] a, input logic [63:0] d);
    req = r; we = w; addr = a; wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int c, input logic [15:0] d);
    sb_t it;
    it.client = 2'(c);
    it.data   = d;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [3:0] exp_rv);
    sb_t it;
    check("rvalid", 64'(rvalid), 64'(exp_rv));
    for (int i = 0; i < 4; i++) begin
      if (rvalid[i]) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: rvalid[%0d] with no expected read", i);
        end else begin
          it = sb_q.pop_front();
          check("rd_client", 64'(i), 64'(it.client));
          check("rdata", 64'(rdata[i*16 +: 16]), 64'(it.data));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    apply(4'b0, 4'b0, 12'h0, 64'h0);

    for (int i = 0; i < 8; i++) begin
      bd_we   = 1'b1;
      bd_addr = 3'(i);
      bd_data = (i == 3) ? 16'h0033 : (i == 6) ? 16'h0066 : 16'(i);
      step();
    end
    bd_we = 1'b0;
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_load", 64'(ram_load), 64'h0);
    reset = 1'b0;
    step();

    // Addr fields packed {c3,c2,c1,c0}; wdata/rd packed as 16-bit words likewise.
    vecs[0]  = '{req:4'b0001, we:4'b0001, addr:{3'd0,3'd0,3'd0,3'd5}, wdata:64'h00AA,
                 gnt:4'b0001, load:1'b1, a1:3'd5, a2:3'd0, din:16'h00AA, rd:64'h0};
    vecs[1]  = '{req:4'b0001, we:4'b0000, addr:{3'd0,3'd0,3'd0,3'd5}, wdata:64'h0,
                 gnt:4'b0001, load:1'b0, a1:3'd5, a2:3'd0, din:16'h0, rd:64'h00AA};
    vecs[2]  = '{req:4'b0000, we:4'b0000, addr:12'h0, wdata:64'h0,
                 gnt:4'b0000, load:1'b0, a1:3'd0, a2:3'd0, din:16'h0, rd:64'h0};
    vecs[3]  = '{req:4'b1000, we:4'b0000, addr:{3'd7,3'd0,3'd0,3'd0}, wdata:64'h0,
                 gnt:4'b1000, load:1'b0, a1:3'd7, a2:3'd0, din:16'h0, rd:{16'h0007,48'h0}};
    vecs[4]  = '{req:4'b0110, we:4'b0000, addr:{3'd0,3'd6,3'd3,3'd0}, wdata:64'h0,
                 gnt:4'b0110, load:1'b0, a1:3'd3, a2:3'd6, din:16'h0,
                 rd:{16'h0,16'h0066,16'h0033,16'h0}};
    vecs[5]  = '{req:4'b1111, we:4'b0000, addr:{3'd4,3'd2,3'd1,3'd0}, wdata:64'h0,
                 gnt:4'b1001, load:1'b0, a1:3'd4, a2:3'd0, din:16'h0,
                 rd:{16'h0004,16'h0,16'h0,16'h0000}};
    vecs[6]  = '{req:4'b1000, we:4'b0000, addr:{3'd7,3'd0,3'd0,3'd0}, wdata:64'h0,
                 gnt:4'b1000, load:1'b0, a1:3'd7, a2:3'd0, din:16'h0, rd:{16'h0007,48'h0}};
    vecs[7]  = '{req:4'b0111, we:4'b0110, addr:{3'd0,3'd0,3'd4,3'd1},
                 wdata:{16'h0,16'h2222,16'h4444,16'h0},
                 gnt:4'b0001, load:1'b0, a1:3'd1, a2:3'd0, din:16'h0, rd:64'h0001};
    vecs[8]  = '{req:4'b0110, we:4'b0110, addr:{3'd0,3'd0,3'd4,3'd1},
                 wdata:{16'h0,16'h2222,16'h4444,16'h0},
                 gnt:4'b0010, load:1'b1, a1:3'd4, a2:3'd0, din:16'h4444, rd:64'h0};
    vecs[9]  = '{req:4'b0100, we:4'b0100, addr:{3'd0,3'd0,3'd4,3'd1},
                 wdata:{16'h0,16'h2222,16'h4444,16'h0},
                 gnt:4'b0100, load:1'b1, a1:3'd0, a2:3'd0, din:16'h2222, rd:64'h0};
    vecs[10] = '{req:4'b0011, we:4'b0001, addr:{3'd0,3'd0,3'd2,3'd2}, wdata:64'h1234,
                 gnt:4'b0011, load:1'b1, a1:3'd2, a2:3'd2, din:16'h1234,
                 rd:{16'h0,16'h0,16'h0002,16'h0}};
    vecs[11] = '{req:4'b0010, we:4'b0000, addr:{3'd0,3'd0,3'd2,3'd0}, wdata:64'h0,
                 gnt:4'b0010, load:1'b0, a1:3'd2, a2:3'd0, din:16'h0,
                 rd:{16'h0,16'h0,16'h1234,16'h0}};

    for (int v = 0; v < 12; v++) begin
      apply(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      #1;
      check($sformatf("v%0d_gnt", v), 64'(gnt), 64'(vecs[v].gnt));
      check($sformatf("v%0d_load", v), 64'(ram_load), 64'(vecs[v].load));
      check($sformatf("v%0d_a1", v), 64'(ram_address1), 64'(vecs[v].a1));
      check($sformatf("v%0d_a2", v), 64'(ram_address2), 64'(vecs[v].a2));
      check($sformatf("v%0d_din", v), 64'(ram_in), 64'(vecs[v].din));
      for (int i = 0; i < 4; i++)
        if (vecs[v].gnt[i] && !vecs[v].we[i]) sb_push(i, vecs[v].rd[i*16 +: 16]);
      step();
      sb_check(vecs[v].gnt & ~vecs[v].we);
    end
    apply(4'b0, 4'b0, 12'h0, 64'h0);
    step();
    check("rdata0_hold", 64'(rdata[15:0]), 64'h0001);

    // Fairness: all four clients write continuously from ptr = 0.
    reset = 1'b1;
    #1;
    check("rst2_rdata", rdata, 64'h0);
    step();
    reset = 1'b0;
    apply(4'b1111, 4'b1111, {3'd3,3'd2,3'd1,3'd0},
          {16'h0F03,16'h0F02,16'h0F01,16'h0F00});
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("fair%0d_gnt", c), 64'(gnt), 64'(4'b0001 << (c % 4)));
      check($sformatf("fair%0d_a1", c), 64'(ram_address1), 64'(c % 4));
      step();
      check($sformatf("fair%0d_rvalid", c), 64'(rvalid), 64'h0);
    end

    // Mid-transfer reset: client 3's write to addr 7 is granted, then reset hits.
    apply(4'b1000, 4'b1000, {3'd7,3'd0,3'd0,3'd0}, {16'hDEAD,48'h0});
    #1;
    check("mid_gnt", 64'(gnt), 64'b1000);
    check("mid_load_pre", 64'(ram_load), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_load_rst", 64'(ram_load), 64'h0);
    check("mid_rvalid", 64'(rvalid), 64'h0);
    check("mid_rdata", rdata, 64'h0);
    step();
    check("mid_mem7", 64'(mem[7]), 64'h0007);
    apply(4'b0, 4'b0, 12'h0, 64'h0);
    step();
    check("mid_rdata_held", rdata, 64'h0);
    reset = 1'b0;

    // ptr must restart at 0: clients 0 and 1 win both ports.
    apply(4'b1111, 4'b0000, {3'd3,3'd2,3'd1,3'd0}, 64'h0);
    #1;
    check("post_gnt", 64'(gnt), 64'b0011);
    check("post_a2", 64'(ram_address2), 64'h1);
    sb_push(0, 16'h0F00);
    sb_push(1, 16'h0F01);
    step();
    apply(4'b0, 4'b0, 12'h0, 64'h0);
    sb_check(4'b0011);
    step();
    sb_check(4'b0000);
    check("sb_drain", 64'(sb_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one RAMp2 instance (one read/write port 1, one read-only port 2) among N requesters.
- Each cycle grants up to two requests:
  - Port 1 serves one read or write.
  - Port 2 serves one additional read.
- Read data is registered and returned one cycle after acceptance with a per-client valid pulse.
- Sits between CPU/peripheral-side request sources and the RAMp2 memory.

Parameters:
- width, 16, data word width; must match RAMp2 width.
- k, 3, address width; RAM depth 2**k; must match RAMp2 k.
- n, 4, number of requesters (2..8).
- lg, 2, width of the round-robin pointer; equals ceil(log2 n).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  n  per-client request, held until granted.
- we  input  n  per-client direction: 1 = write, 0 = read. Valid while req is high.
- addr  input  n*k  per-client address; client i uses bits [i*k +: k].
- wdata  input  n*width  per-client write data; client i uses bits [i*width +: width].
- gnt  output  n  combinational grant; a transfer occurs at the clock edge where req[i] and gnt[i] are both high.
- rvalid  output  n  registered one-cycle pulse: client i's read completed.
- rdata  output  n*width  registered per-client read data; holds its value until the next read for that client.
- ram_load  output  1  to RAMp2 load.
- ram_in  output  width  to RAMp2 in.
- ram_address1  output  k  to RAMp2 address1.
- ram_address2  output  k  to RAMp2 address2.
- ram_out1  input  width  from RAMp2 out1 (combinational read).
- ram_out2  input  width  from RAMp2 out2 (combinational read).

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - ptr = 0, rvalid = 0, every rdata word = 0.
  - A transfer in flight at reset is discarded; the RAM write is suppressed because ram_load is forced 0 while reset is high.
- RR order: clients ptr, ptr+1, …, ptr+n-1, modulo n.
- Port 1 winner (w1): the first client in RR order with req = 1.
- Port 2 winner (w2): the first client after w1 in RR order with req = 1 and we = 0.
  - Only clients between w1 and ptr-1 (modulo n) are searched.
  - w2 never equals w1.
  - No w2 if there is no w1.
- gnt[w1] = 1 and gnt[w2] = 1; all other gnt bits = 0. gnt is purely combinational from req, we and ptr.
- RAM drive:
  - ram_address1 = addr[w1].
  - If we[w1] = 1: ram_load = 1 and ram_in = wdata[w1].
  - ram_address2 = addr[w2].
  - Idle port: address 0. ram_load = 0 and ram_in = 0 unless port 1 is writing.
- Read completion at each edge:
  - w1 read: rdata[w1] <= ram_out1 and rvalid[w1] <= 1.
  - w2: rdata[w2] <= ram_out2 and rvalid[w2] <= 1.
  - All other rvalid bits <= 0.
- Writes produce no rvalid. The write is complete at the accepting edge.
- Latency:
  - Grant: 0 cycles (same cycle as req, if the client wins).
  - Read data: 1 cycle after acceptance.
  - A client may issue back-to-back requests. A new req in the cycle rvalid is high is legal.
- Pointer update at each edge with any grant: ptr <= (last granted index + 1) mod n. The last granted index is w2 if present, else w1. No grant: ptr holds.
- Fairness: every requester becomes w1 within n cycles, so writes cannot starve.
- Simultaneous write (port 1) and read (port 2) to the same address: the read returns the old data (read-before-write); the write lands at the same edge.
- Simultaneous reads of the same address on both ports: both return the same data.
- Address wrap is not applicable: addresses are exactly k bits.
- Changing req, we, addr or wdata while gnt is low has no effect. Once asserted, req must stay high until granted.

Decomposition:
- Shared include holds:
  - Default width, k and n constants.
  - Helper function idx_wrap(i, n).
- Sub-module rr_pick:
  - Rotating first-one finder. Inputs: n-bit mask, start index. Outputs: found flag, index.
  - Instantiated twice: w1 uses mask req starting at ptr; w2 uses mask req & ~we, restricted to the search window after w1.

Test Plan:
- Reset then single client. Client 0 writes 0x00AA to addr 5, then reads addr 5:
  - gnt[0] is high in both cycles.
  - rvalid[0] pulses one cycle after the read with rdata[0] = 0x00AA.
  - ram_load is high only during the write cycle.
- Dual read. Clients 1 and 2 read addr 3 (holding 0x0033) and addr 6 (holding 0x0066) in the same cycle with ptr = 0:
  - gnt = 0110.
  - Next cycle rvalid = 0110, rdata[1] = 0x0033, rdata[2] = 0x0066.
  - ptr = 3.
- Fairness. All 4 clients write continuously:
  - gnt sequence is 0001, 0010, 0100, 1000 repeating.
  - No cycle has two grants.
- Hazard. Client 0 writes 0x1234 to addr 2 (old value 0x0002) while client 1 reads addr 2 in the same cycle:
  - rdata[1] = 0x0002.
  - A later read of addr 2 returns 0x1234.
- Port-2 write exclusion. Client 0 reads and clients 1 and 2 write, ptr = 0:
  - gnt = 0001 (the writes cannot use port 2).
  - Next cycle client 1 wins.
- Mid-operation reset. Assert reset asynchronously while client 3 has a write granted:
  - ram_load drops immediately and addr 7 is unchanged.
  - rvalid = 0, rdata = 0, ptr = 0 until reset is released.
